// File: rtl/detector_event_logger.sv
// detector_event_logger: time-stamps edges of the detector flag into a show-ahead FIFO with edge counters.
// Define DET_LOG_GLITCH_FILTER_EN to require two consecutive differing enabled samples before accepting a change.
module detector_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            f_in,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic            ev_rise,
  output logic [TS_W-1:0] ev_time,
  output logic [7:0]      rise_cnt,
  output logic [7:0]      fall_cnt,
  output logic            overflow,
  input  logic            clr_ovf,
  output logic            level
);
  localparam int AW = $clog2(DEPTH);

  logic            level_q, ovf_q;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic [7:0]      rise_q, fall_q;
  logic            rise_mem [DEPTH];
  logic [TS_W-1:0] time_mem [DEPTH];
  logic            diff, evt, pop, full, push, drop;

  assign diff = en && (f_in != level_q);

`ifdef DET_LOG_GLITCH_FILTER_EN
  // pend_q marks that the previous enabled sample already differed from level
  logic pend_q;
  assign evt = diff && pend_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= 1'b0;
    else if (en) pend_q <= diff && !pend_q;
`else
  assign evt = diff;
`endif

  assign pop  = ev_valid && ev_ready;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      ovf_q   <= 1'b0;
      ts_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      if (en) ts_q <= ts_q + 1'b1;
      if (evt) level_q <= f_in;
      if (evt && f_in && rise_q != 8'hff) rise_q <= rise_q + 1'b1;
      if (evt && !f_in && fall_q != 8'hff) fall_q <= fall_q + 1'b1;
      ovf_q <= drop || (ovf_q && !clr_ovf);
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk)
    if (push) begin
      rise_mem[wp_q] <= f_in;
      time_mem[wp_q] <= ts_q;
    end

  assign ev_valid = cnt_q != '0;
  assign ev_rise  = ev_valid && rise_mem[rp_q];
  assign ev_time  = ev_valid ? time_mem[rp_q] : '0;
  assign rise_cnt = rise_q;
  assign fall_cnt = fall_q;
  assign overflow = ovf_q;
  assign level    = level_q;
endmodule

// File: tb/tb_detector_event_logger.sv
// tb_detector_event_logger: scenario tasks plus randomized run checked against a queue-based event model.
module tb_detector_event_logger;
  localparam int TS_W  = 4;
  localparam int DEPTH = 8;

  logic clk = 0, rst_n = 0, en = 0, f_in = 0, ev_ready = 0, clr_ovf = 0;
  logic ev_valid, ev_rise, overflow, level;
  logic [TS_W-1:0] ev_time;
  logic [7:0] rise_cnt, fall_cnt;

  detector_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .f_in(f_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_rise(ev_rise), .ev_time(ev_time), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
    .overflow(overflow), .clr_ovf(clr_ovf), .level(level)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  typedef struct packed {logic rise; logic [TS_W-1:0] t;} ev_t;
  ev_t  mq[$];
  logic m_level, m_pend, m_ovf;
  int   m_ts, m_rc, m_fc;

  function automatic logic e_valid();
    return mq.size() != 0;
  endfunction
  function automatic logic e_rise();
    return mq.size() != 0 ? mq[0].rise : 1'b0;
  endfunction
  function automatic logic [TS_W-1:0] e_time();
    return mq.size() != 0 ? mq[0].t : '0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_level = 0; m_pend = 0; m_ovf = 0; m_ts = 0; m_rc = 0; m_fc = 0;
  endtask

  // drive one clock of inputs, advance the model by the spec rules, sample 1 time unit after the edge
  task automatic cyc(input logic e, input logic f, input logic r, input logic c);
    logic diff, evt, pop, drop;
    en = e; f_in = f; ev_ready = r; clr_ovf = c;
    pop  = mq.size() != 0 && r;
    diff = e && (f != m_level);
`ifdef DET_LOG_GLITCH_FILTER_EN
    evt = diff && m_pend;
    if (e) m_pend = diff && !m_pend;
`else
    evt = diff;
`endif
    drop = evt && mq.size() == DEPTH && !pop;
    if (pop) void'(mq.pop_front());
    if (evt && !drop) mq.push_back(ev_t'{rise: f, t: TS_W'(m_ts)});
    if (evt && f) m_rc = m_rc < 255 ? m_rc + 1 : 255;
    if (evt && !f) m_fc = m_fc < 255 ? m_fc + 1 : 255;
    m_ovf = drop ? 1'b1 : c ? 1'b0 : m_ovf;
    if (evt) m_level = f;
    if (e) m_ts = (m_ts + 1) % (1 << TS_W);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en = 0; ev_ready = 0; clr_ovf = 0;
    #2 rst_n = 0;
    #1 m_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    en = 0; ev_ready = 0; clr_ovf = 0;
    #2 rst_n = 0;
    #1 m_reset();
    total += 7;
    if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %0d expected 0", ev_valid); else passed++;
    if (ev_rise !== 1'b0) $display("FAIL reset_rise: got %0d expected 0", ev_rise); else passed++;
    if (ev_time !== '0) $display("FAIL reset_time: got %0d expected 0", ev_time); else passed++;
    if (rise_cnt !== 8'd0) $display("FAIL reset_rise_cnt: got %0d expected 0", rise_cnt); else passed++;
    if (fall_cnt !== 8'd0) $display("FAIL reset_fall_cnt: got %0d expected 0", fall_cnt); else passed++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0d expected 0", overflow); else passed++;
    if (level !== 1'b0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single_rise();
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
`ifdef DET_LOG_GLITCH_FILTER_EN
    total++;
    if (ev_valid !== 1'b0) $display("FAIL filter_first_sample: got %0d expected 0", ev_valid); else passed++;
    cyc(1, 1, 0, 0);
`endif
    total += 4;
    if (ev_valid !== 1'b1) $display("FAIL single_valid: got %0d expected 1", ev_valid); else passed++;
    if (ev_rise !== 1'b1) $display("FAIL single_rise: got %0d expected 1", ev_rise); else passed++;
    if (ev_time !== e_time()) $display("FAIL single_time: got %0d expected %0d", ev_time, e_time()); else passed++;
    if (rise_cnt !== 8'(m_rc)) $display("FAIL single_rise_cnt: got %0d expected %0d", rise_cnt, m_rc); else passed++;
  endtask

  task automatic test_pair_hold();
    logic hr;
    logic [TS_W-1:0] ht;
    do_reset();
    for (int t = 0; t < 14; t++) cyc(1, (t >= 5 && t < 9), 0, 0);
    hr = ev_rise; ht = ev_time;
    total += 3;
    if (ev_valid !== 1'b1) $display("FAIL pair_valid: got %0d expected 1", ev_valid); else passed++;
    if (ev_rise !== e_rise()) $display("FAIL pair_head_rise: got %0d expected %0d", ev_rise, e_rise()); else passed++;
    if (ev_time !== e_time()) $display("FAIL pair_head_time: got %0d expected %0d", ev_time, e_time()); else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc(i[0], i[1], 0, 0);
      total++;
      if (ev_rise !== hr || ev_time !== ht)
        $display("FAIL pair_stable: got %0d/%0d expected %0d/%0d", ev_rise, ev_time, hr, ht);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0);
      total += 3;
      if (ev_valid !== e_valid()) $display("FAIL pair_pop_valid: got %0d expected %0d", ev_valid, e_valid()); else passed++;
      if (ev_rise !== e_rise()) $display("FAIL pair_pop_rise: got %0d expected %0d", ev_rise, e_rise()); else passed++;
      if (ev_time !== e_time()) $display("FAIL pair_pop_time: got %0d expected %0d", ev_time, e_time()); else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(1, ~i[0], 0, 0);
      cyc(1, ~i[0], 0, 0);
    end
    total += 3;
    if (int'(rise_cnt) + int'(fall_cnt) != 9) $display("FAIL ovf_counts: got %0d expected 9", int'(rise_cnt) + int'(fall_cnt)); else passed++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0d expected 1", overflow); else passed++;
    if (mq.size() != DEPTH) $display("FAIL ovf_model_depth: got %0d expected %0d", mq.size(), DEPTH); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      total += 2;
      if (ev_valid !== 1'b1) $display("FAIL ovf_drain_valid: got %0d expected 1", ev_valid); else passed++;
      if (ev_rise !== e_rise() || ev_time !== e_time())
        $display("FAIL ovf_drain_entry: got %0d/%0d expected %0d/%0d", ev_rise, ev_time, e_rise(), e_time());
      else passed++;
      cyc(0, 0, 1, 0);
    end
    total += 2;
    if (ev_valid !== 1'b0) $display("FAIL ovf_drained: got %0d expected 0", ev_valid); else passed++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0d expected 1", overflow); else passed++;
    cyc(0, 0, 0, 1);
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0d expected 0", overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic nv;
    int n;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, ~i[0], 0, 0);
      cyc(1, ~i[0], 0, 0);
    end
    nv = ~m_level;
`ifdef DET_LOG_GLITCH_FILTER_EN
    cyc(1, nv, 0, 0);
`endif
    cyc(1, nv, 1, 0);
    total += 3;
    if (overflow !== 1'b0) $display("FAIL full_pp_ovf: got %0d expected 0", overflow); else passed++;
    if (mq.size() != DEPTH) $display("FAIL full_pp_model_depth: got %0d expected %0d", mq.size(), DEPTH); else passed++;
    if (ev_time !== e_time()) $display("FAIL full_pp_head: got %0d expected %0d", ev_time, e_time()); else passed++;
    n = 0;
    while (ev_valid === 1'b1 && n < 2 * DEPTH) begin
      total++;
      if (ev_rise !== e_rise() || ev_time !== e_time())
        $display("FAIL full_pp_entry: got %0d/%0d expected %0d/%0d", ev_rise, ev_time, e_rise(), e_time());
      else passed++;
      cyc(0, 0, 1, 0);
      n++;
    end
    total++;
    if (n != DEPTH) $display("FAIL full_pp_occupancy: got %0d expected %0d", n, DEPTH); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, ~i[0], 0, 0);
      cyc(1, ~i[0], 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      total += 2;
      if (ev_valid !== e_valid()) $display("FAIL b2b_valid: got %0d expected %0d", ev_valid, e_valid()); else passed++;
      if (ev_time !== e_time()) $display("FAIL b2b_time: got %0d expected %0d", ev_time, e_time()); else passed++;
    end
  endtask

  task automatic test_en_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
    end
    total += 2;
    if (ev_valid !== 1'b0) $display("FAIL en_ignored_valid: got %0d expected 0", ev_valid); else passed++;
    if (level !== 1'b0) $display("FAIL en_ignored_level: got %0d expected 0", level); else passed++;
    cyc(1, 1, 0, 0);
`ifdef DET_LOG_GLITCH_FILTER_EN
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
`endif
    total += 3;
    if (ev_valid !== 1'b1) $display("FAIL wrap_valid: got %0d expected 1", ev_valid); else passed++;
    if (ev_time !== e_time()) $display("FAIL wrap_time: got %0d expected %0d", ev_time, e_time()); else passed++;
    if (level !== 1'b1) $display("FAIL wrap_level: got %0d expected 1", level); else passed++;
  endtask

  task automatic test_random();
    logic f;
    f = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        f = 0;
        total += 2;
        if (ev_valid !== 1'b0) $display("FAIL rand_reset_valid: got %0d expected 0", ev_valid); else passed++;
        if (level !== 1'b0) $display("FAIL rand_reset_level: got %0d expected 0", level); else passed++;
      end
      if ($urandom_range(0, 2) == 0) f = ~f;
      cyc($urandom_range(0, 3) != 0, f, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      total++;
      if (ev_valid !== e_valid() || ev_rise !== e_rise() || ev_time !== e_time() ||
          rise_cnt !== 8'(m_rc) || fall_cnt !== 8'(m_fc) || overflow !== m_ovf || level !== m_level)
        $display("FAIL rand_cycle%0d: got v%0d r%0d t%0d rc%0d fc%0d o%0d l%0d expected v%0d r%0d t%0d rc%0d fc%0d o%0d l%0d",
                 i, ev_valid, ev_rise, ev_time, rise_cnt, fall_cnt, overflow, level,
                 e_valid(), e_rise(), e_time(), m_rc, m_fc, m_ovf, m_level);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      cyc(1, 1, 1, 0);
      cyc(1, 1, 1, 0);
      cyc(1, 0, 1, 0);
      cyc(1, 0, 1, 0);
    end
    total += 2;
    if (rise_cnt !== 8'd255) $display("FAIL sat_rise: got %0d expected 255", rise_cnt); else passed++;
    if (fall_cnt !== 8'd255) $display("FAIL sat_fall: got %0d expected 255", fall_cnt); else passed++;
  endtask

  initial begin
    m_reset();
    #2 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    test_reset();
    test_single_rise();
    test_pair_hold();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_en_wrap();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
